// File: rtl/font_rom_arbiter.sv
// rtl/font_rom_arbiter.sv - two-port fixed-priority font ROM arbiter with starvation guard
// Optional statistics counters enabled by defining FONTARB_STATS_EN.
module font_rom_arbiter #(
    parameter int ADDR_W   = 6,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              valid0,
    output logic [DATA_W-1:0] data0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              valid1,
    output logic [DATA_W-1:0] data1,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
`ifdef FONTARB_STATS_EN
    ,
    output logic [15:0]       conflict_cnt,
    output logic [15:0]       force_cnt
`endif
);

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0] rom_addr_q;
    logic              tag1_v_q, tag1_p_q, tag2_v_q, tag2_p_q;
    logic [DATA_W-1:0] data0_q, data1_q;
    logic              force1;

    assign force1 = (wait_cnt_q == MAX_WAIT_C);

    // Grants are gated by reset so nothing is issued while the block is held.
    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        rom_addr = rom_addr_q;
        if (reset_n) begin
            if (req1 && (force1 || !req0)) begin
                gnt1     = 1'b1;
                rom_addr = addr1;
            end else if (req0) begin
                gnt0     = 1'b1;
                rom_addr = addr0;
            end
        end
    end

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!req1 || gnt1)
            wait_cnt_d = 8'd0;
        else if (wait_cnt_q < MAX_WAIT_C)
            wait_cnt_d = wait_cnt_q + 8'd1;
    end

    // Stage 1 tags the cycle the ROM sees the address; stage 2 marks returned data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wait_cnt_q <= 8'd0;
            rom_addr_q <= '0;
            tag1_v_q   <= 1'b0;
            tag1_p_q   <= 1'b0;
            tag2_v_q   <= 1'b0;
            tag2_p_q   <= 1'b0;
            data0_q    <= '0;
            data1_q    <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            rom_addr_q <= rom_addr;
            tag1_v_q   <= gnt0 || gnt1;
            tag1_p_q   <= gnt1;
            tag2_v_q   <= tag1_v_q;
            tag2_p_q   <= tag1_p_q;
            if (tag1_v_q && !tag1_p_q)
                data0_q <= rom_data;
            if (tag1_v_q && tag1_p_q)
                data1_q <= rom_data;
        end
    end

    assign valid0 = tag2_v_q && !tag2_p_q;
    assign valid1 = tag2_v_q && tag2_p_q;
    assign data0  = data0_q;
    assign data1  = data1_q;

`ifdef FONTARB_STATS_EN
    logic [15:0] conflict_q, force_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            conflict_q <= 16'd0;
            force_q    <= 16'd0;
        end else begin
            if (req0 && req1 && conflict_q != 16'hFFFF)
                conflict_q <= conflict_q + 16'd1;
            // Only a forced win over a pending port 0 request counts.
            if (gnt1 && force1 && req0 && force_q != 16'hFFFF)
                force_q <= force_q + 16'd1;
        end
    end

    assign conflict_cnt = conflict_q;
    assign force_cnt    = force_q;
`endif

endmodule

// File: tb/tb_font_rom_arbiter.sv
// tb/tb_font_rom_arbiter.sv - directed self-checking bench for font_rom_arbiter
module tb_font_rom_arbiter;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       req0, req1;
    logic [5:0] addr0, addr1;
    logic       gnt0, gnt1, valid0, valid1;
    logic [7:0] data0, data1;
    logic [5:0] rom_addr;
    logic [7:0] rom_data;
`ifdef FONTARB_STATS_EN
    logic [15:0] conflict_cnt, force_cnt;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    font_rom_arbiter #(.ADDR_W(6), .DATA_W(8), .MAX_WAIT(7)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req0     (req0),
        .addr0    (addr0),
        .gnt0     (gnt0),
        .valid0   (valid0),
        .data0    (data0),
        .req1     (req1),
        .addr1    (addr1),
        .gnt1     (gnt1),
        .valid1   (valid1),
        .data1    (data1),
        .rom_addr (rom_addr),
        .rom_data (rom_data)
`ifdef FONTARB_STATS_EN
        ,
        .conflict_cnt (conflict_cnt),
        .force_cnt    (force_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_fn(input logic [5:0] a);
        if (a == 6'h13)
            return 8'h3C;
        return {a, 2'b10} ^ 8'h5A;
    endfunction

    always @(posedge clk) rom_data <= rom_fn(rom_addr);

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
        repeat (3) next_cycle();
        #1;
        total_cnt++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) $display("FAIL reset_gnt gnt0=%b gnt1=%b need 0 0", gnt0, gnt1); else pass_cnt++;
        total_cnt++; if (valid0 !== 1'b0 || valid1 !== 1'b0) $display("FAIL reset_valid valid0=%b valid1=%b need 0 0", valid0, valid1); else pass_cnt++;
        total_cnt++; if (data0 !== 8'h00 || data1 !== 8'h00) $display("FAIL reset_data data0=%h data1=%h need 00 00", data0, data1); else pass_cnt++;
        total_cnt++; if (rom_addr !== 6'h00) $display("FAIL reset_rom_addr got %h need 00", rom_addr); else pass_cnt++;
`ifdef FONTARB_STATS_EN
        total_cnt++; if (conflict_cnt !== 16'd0 || force_cnt !== 16'd0) $display("FAIL reset_stats conflict=%0d force=%0d need 0 0", conflict_cnt, force_cnt); else pass_cnt++;
`endif
        next_cycle();
        reset_n = 1'b1;
    endtask

    task automatic test_single_port0();
        next_cycle();
        req0 = 1'b1; addr0 = 6'h13;
        #1;
        total_cnt++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) $display("FAIL single_gnt gnt0=%b gnt1=%b need 1 0", gnt0, gnt1); else pass_cnt++;
        total_cnt++; if (rom_addr !== 6'h13) $display("FAIL single_rom_addr got %h need 13", rom_addr); else pass_cnt++;
        next_cycle();
        req0 = 1'b0; addr0 = 6'h07;
        #1;
        total_cnt++; if (valid0 !== 1'b0) $display("FAIL single_early_valid got %b need 0", valid0); else pass_cnt++;
        total_cnt++; if (rom_addr !== 6'h13) $display("FAIL single_addr_hold got %h need 13", rom_addr); else pass_cnt++;
        next_cycle();
        #1;
        total_cnt++; if (valid0 !== 1'b1 || data0 !== 8'h3C) $display("FAIL single_valid valid0=%b data0=%h need 1 3c", valid0, data0); else pass_cnt++;
        total_cnt++; if (valid1 !== 1'b0 || data1 !== 8'h00) $display("FAIL single_port1_quiet valid1=%b data1=%h need 0 00", valid1, data1); else pass_cnt++;
        next_cycle();
        #1;
        total_cnt++; if (valid0 !== 1'b0 || data0 !== 8'h3C) $display("FAIL single_hold valid0=%b data0=%h need 0 3c", valid0, data0); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        next_cycle();
        for (int c = 0; c < 6; c++) begin
            if (c < 3) begin
                req0 = 1'b1; addr0 = 6'(c);
            end else begin
                req0 = 1'b0;
            end
            #1;
            if (c < 3) begin
                total_cnt++; if (gnt0 !== 1'b1) $display("FAIL b2b_gnt%0d got %b need 1", c, gnt0); else pass_cnt++;
            end
            if (c >= 2 && c < 5) begin
                total_cnt++;
                if (valid0 !== 1'b1 || data0 !== rom_fn(6'(c - 2)))
                    $display("FAIL b2b_data%0d valid0=%b data0=%h need 1 %h", c - 2, valid0, data0, rom_fn(6'(c - 2)));
                else pass_cnt++;
            end
            if (c == 5) begin
                total_cnt++; if (valid0 !== 1'b0) $display("FAIL b2b_end valid0=%b need 0", valid0); else pass_cnt++;
            end
            next_cycle();
        end
    endtask

    task automatic test_idle_port0();
        req1 = 1'b1; addr1 = 6'h2F;
        #1;
        total_cnt++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) $display("FAIL idle_gnt gnt1=%b gnt0=%b need 1 0", gnt1, gnt0); else pass_cnt++;
        total_cnt++; if (rom_addr !== 6'h2F) $display("FAIL idle_rom_addr got %h need 2f", rom_addr); else pass_cnt++;
        next_cycle();
        req1 = 1'b0;
        next_cycle();
        #1;
        total_cnt++; if (valid1 !== 1'b1 || data1 !== rom_fn(6'h2F)) $display("FAIL idle_data valid1=%b data1=%h need 1 %h", valid1, data1, rom_fn(6'h2F)); else pass_cnt++;
        total_cnt++; if (valid0 !== 1'b0 || data0 !== rom_fn(6'h02)) $display("FAIL idle_data0_hold valid0=%b data0=%h need 0 %h", valid0, data0, rom_fn(6'h02)); else pass_cnt++;
        next_cycle();
    endtask

    task automatic test_contention();
        logic exp1;
        logic exp_v0;
        for (int c = 0; c < 16; c++) begin
            req0 = 1'b1; addr0 = 6'h0A;
            req1 = 1'b1; addr1 = 6'h21;
            #1;
            exp1 = (c == 7) || (c == 15);
            total_cnt++;
            if (gnt1 !== exp1 || gnt0 !== !exp1)
                $display("FAIL cont_gnt c%0d gnt0=%b gnt1=%b need %b %b", c, gnt0, gnt1, !exp1, exp1);
            else pass_cnt++;
            total_cnt++;
            if (rom_addr !== (exp1 ? 6'h21 : 6'h0A))
                $display("FAIL cont_rom_addr c%0d got %h need %h", c, rom_addr, exp1 ? 6'h21 : 6'h0A);
            else pass_cnt++;
            if (c >= 2) begin
                exp_v0 = (c != 9);
                total_cnt++;
                if (valid0 !== exp_v0 || valid1 !== !exp_v0)
                    $display("FAIL cont_valid c%0d valid0=%b valid1=%b need %b %b", c, valid0, valid1, exp_v0, !exp_v0);
                else pass_cnt++;
            end
            if (c == 8) begin
                total_cnt++; if (dut.wait_cnt_q !== 8'd0) $display("FAIL cont_wait_clear got %0d need 0", dut.wait_cnt_q); else pass_cnt++;
            end
            if (c == 9) begin
                total_cnt++; if (data1 !== rom_fn(6'h21)) $display("FAIL cont_data1 got %h need %h", data1, rom_fn(6'h21)); else pass_cnt++;
            end
            next_cycle();
        end
        req0 = 1'b0; req1 = 1'b0;
`ifdef FONTARB_STATS_EN
        total_cnt++; if (conflict_cnt !== 16'd16) $display("FAIL stats_conflict got %0d need 16", conflict_cnt); else pass_cnt++;
        total_cnt++; if (force_cnt !== 16'd2) $display("FAIL stats_force got %0d need 2", force_cnt); else pass_cnt++;
`endif
        repeat (3) next_cycle();
        total_cnt++; if (data0 !== rom_fn(6'h0A)) $display("FAIL cont_data0 got %h need %h", data0, rom_fn(6'h0A)); else pass_cnt++;
    endtask

    task automatic test_reset_mid_flight();
        req0 = 1'b1; addr0 = 6'h05;
        #1;
        total_cnt++; if (gnt0 !== 1'b1) $display("FAIL mid_gnt got %b need 1", gnt0); else pass_cnt++;
        next_cycle();
        reset_n = 1'b0;
        #1;
        total_cnt++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) $display("FAIL mid_gnt_in_reset gnt0=%b gnt1=%b need 0 0", gnt0, gnt1); else pass_cnt++;
        total_cnt++; if (data0 !== 8'h00 || rom_addr !== 6'h00) $display("FAIL mid_clear data0=%h rom_addr=%h need 00 00", data0, rom_addr); else pass_cnt++;
        next_cycle();
        req0 = 1'b0;
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            total_cnt++; if (valid0 !== 1'b0 || valid1 !== 1'b0) $display("FAIL mid_no_valid c%0d valid0=%b valid1=%b need 0 0", c, valid0, valid1); else pass_cnt++;
            next_cycle();
        end
        req0 = 1'b1; addr0 = 6'h3F;
        #1;
        total_cnt++; if (gnt0 !== 1'b1) $display("FAIL post_gnt got %b need 1", gnt0); else pass_cnt++;
        next_cycle();
        req0 = 1'b0;
        next_cycle();
        #1;
        total_cnt++; if (valid0 !== 1'b1 || data0 !== rom_fn(6'h3F)) $display("FAIL post_data valid0=%b data0=%h need 1 %h", valid0, data0, rom_fn(6'h3F)); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single_port0();
        test_back_to_back();
        test_idle_port0();
        test_contention();
        test_reset_mid_flight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
